// File: rtl/sd_dnsize_pkg.sv
// rtl/sd_dnsize_pkg.sv - shared types and parameter checks for the sd_dnsize width down-converter
//
// Purpose : state encoding and elaboration-time parameter validation used by sd_dnsize.
// Contents:
//    state_e   - serializer state: IDLE (no beat held) / SEND (beat presented)
//    params_ok - true when width_in is a multiple of ratio and ratio >= 2

package sd_dnsize_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic bit params_ok(input int width_in, input int ratio);
      return (ratio >= 2) && ((width_in % ratio) == 0);
   endfunction

endpackage

// File: rtl/sd_dnsize.sv
// rtl/sd_dnsize.sv - srdy/drdy width down-converter, one wide word to 1..ratio narrow beats
//
// Purpose : takes one width_in word per transaction and emits c_nbeats+1 beats of
//           width_out bits, lowest slice first, at up to one beat per clock. A new word
//           is accepted in the same cycle the last beat of the previous word pops, so
//           back-to-back words stream without a bubble.
//
// Parameters:
//    width_in  - input word width (multiple of ratio)
//    ratio     - maximum beats per word (>= 2)
//
// Ports:
//    clk       in   clock
//    reset     in   synchronous, active-high reset
//    c_srdy    in   upstream word valid
//    c_drdy    out  word can be accepted this cycle
//    c_data    in   word; beat k = c_data[k*width_out +: width_out]
//    c_nbeats  in   valid beats minus one
//    p_srdy    out  narrow beat valid (flop-driven)
//    p_drdy    in   downstream accepts beat
//    p_data    out  current beat (flop-driven, low slice of hold register)
//    p_last    out  final beat of the word (only with SD_DNSIZE_LAST_EN defined)
//
// Build option: define SD_DNSIZE_LAST_EN to add the p_last output.

module sd_dnsize
   import sd_dnsize_pkg::*;
#(
   parameter  int width_in  = 64,
   parameter  int ratio     = 4,
   localparam int width_out = width_in / ratio,
   localparam int cw        = $clog2(ratio)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 c_srdy,
   output logic                 c_drdy,
   input  logic [width_in-1:0]  c_data,
   input  logic [cw-1:0]        c_nbeats,
   output logic                 p_srdy,
   input  logic                 p_drdy,
   output logic [width_out-1:0] p_data
`ifdef SD_DNSIZE_LAST_EN
   ,
   output logic                 p_last
`endif
);

   generate
      if (!params_ok(width_in, ratio)) begin : g_param_err
         $fatal(1, "sd_dnsize: width_in must be a multiple of ratio and ratio must be >= 2");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [cw-1:0]       remain_q, remain_d;
   logic [width_in-1:0] hold_q, hold_d;

   logic last_beat;
   logic push;
   logic pop;

   // The current beat is the final one of its word when nothing remains behind it.
   assign last_beat = (state_q == SEND) && (remain_q == '0);

   // p_drdy reaches c_drdy only through the last-beat term; that path is what lets the
   // next word load in the same cycle the previous one finishes.
   assign c_drdy = !reset && ((state_q == IDLE) || (last_beat && p_drdy));

   assign p_srdy = (state_q == SEND);
   assign p_data = hold_q[width_out-1:0];

`ifdef SD_DNSIZE_LAST_EN
   assign p_last = last_beat;
`endif

   assign push = c_srdy && c_drdy;
   assign pop  = p_srdy && p_drdy;

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            if (push) begin
               hold_d   = c_data;
               remain_d = c_nbeats;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (pop) begin
               if (remain_q != '0) begin
                  hold_d   = hold_q >> width_out;
                  remain_d = remain_q - cw'(1);
               end else if (push) begin
                  hold_d   = c_data;
                  remain_d = c_nbeats;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            remain_d = '0;
         end
      endcase
   end

   // Control state: reset abandons any in-flight word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   // Datapath carries no reset; its contents only matter while state_q is SEND.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

endmodule

// File: tb/tb_sd_dnsize.sv
// tb/tb_sd_dnsize.sv - directed and stress bench for sd_dnsize (64-bit in, 4 beats of 16 bits)

module tb_sd_dnsize;

   localparam int NW = 3000;

   logic        clk;
   logic        reset;
   logic        c_srdy;
   logic        c_drdy;
   logic [63:0] c_data;
   logic [1:0]  c_nbeats;
   logic        p_srdy;
   logic        p_drdy;
   logic [15:0] p_data;
`ifdef SD_DNSIZE_LAST_EN
   logic        p_last;
`endif

   int checks = 0;
   int errors = 0;

   sd_dnsize #(.width_in(64), .ratio(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .c_srdy   (c_srdy),
      .c_drdy   (c_drdy),
      .c_data   (c_data),
      .c_nbeats (c_nbeats),
      .p_srdy   (p_srdy),
      .p_drdy   (p_drdy),
      .p_data   (p_data)
`ifdef SD_DNSIZE_LAST_EN
      ,
      .p_last   (p_last)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [63:0] words2 [3];
   logic [1:0]  nb2    [3];
   logic [15:0] exp2   [7];
   logic        exp2_cd[7];
   logic [15:0] exp3   [10];
   logic        pat3   [10];
   logic [15:0] exp_q  [$];

   initial begin
      int w;
      int pushed;
      logic took;
      logic prev_stall;
      logic [15:0] prev_data;
      logic [63:0] word;

      words2 = '{64'h0000_0000_A002_A001, 64'hDEAD_BEEF_CAFE_B001, 64'hC004_C003_C002_C001};
      nb2    = '{2'd1, 2'd0, 2'd3};
      exp2   = '{16'hA001, 16'hA002, 16'hB001, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
      exp2_cd = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      exp3   = '{16'hD001, 16'hD002, 16'hD002, 16'hD002, 16'hD003,
                 16'hD003, 16'hD003, 16'hD004, 16'hD004, 16'hD004};
      pat3   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset
      reset = 1'b1; c_srdy = 1'b0; p_drdy = 1'b0; c_data = '0; c_nbeats = '0;
      tick();
      tick();
      check("reset_cdrdy_low", 64'(c_drdy), 64'(1'b0));
      check("reset_psrdy_low", 64'(p_srdy), 64'(1'b0));
`ifdef SD_DNSIZE_LAST_EN
      check("reset_plast_low", 64'(p_last), 64'(1'b0));
`endif
      reset = 1'b0;
      tick();
      check("post_reset_cdrdy", 64'(c_drdy), 64'(1'b1));
      check("post_reset_psrdy", 64'(p_srdy), 64'(1'b0));

      // Single 4-beat word
      c_data = 64'h4444_3333_2222_1111; c_nbeats = 2'd3; c_srdy = 1'b1; p_drdy = 1'b1;
      #1;
      check("t1_idle_cdrdy", 64'(c_drdy), 64'(1'b1));
      tick();
      c_srdy = 1'b0;
      #1;
      check("t1_b0_srdy", 64'(p_srdy), 64'(1'b1));
      check("t1_b0_data", 64'(p_data), 64'h1111);
      check("t1_b0_cdrdy", 64'(c_drdy), 64'(1'b0));
      tick();
      check("t1_b1_data", 64'(p_data), 64'h2222);
      check("t1_b1_cdrdy", 64'(c_drdy), 64'(1'b0));
      tick();
      check("t1_b2_data", 64'(p_data), 64'h3333);
      check("t1_b2_cdrdy", 64'(c_drdy), 64'(1'b0));
      tick();
      check("t1_b3_data", 64'(p_data), 64'h4444);
      check("t1_b3_srdy", 64'(p_srdy), 64'(1'b1));
      check("t1_b3_cdrdy", 64'(c_drdy), 64'(1'b1));
      tick();
      check("t1_done_srdy", 64'(p_srdy), 64'(1'b0));

      // Back-to-back words, no bubble
      w = 0;
      c_data = words2[0]; c_nbeats = nb2[0]; c_srdy = 1'b1; p_drdy = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         #1;
         if (cyc > 0) begin
            check("t2_srdy", 64'(p_srdy), 64'(1'b1));
            check("t2_data", 64'(p_data), 64'(exp2[cyc-1]));
            check("t2_cdrdy", 64'(c_drdy), 64'(exp2_cd[cyc-1]));
         end
         took = c_srdy && c_drdy;
         tick();
         if (took) begin
            w++;
            if (w < 3) begin
               c_data = words2[w]; c_nbeats = nb2[w];
            end else begin
               c_srdy = 1'b0;
            end
         end
      end
      #1;
      check("t2_words_taken", 64'(w), 64'(3));
      check("t2_done_srdy", 64'(p_srdy), 64'(1'b0));

      // Downstream stalls during a 4-beat word
      c_data = 64'hD004_D003_D002_D001; c_nbeats = 2'd3; c_srdy = 1'b1; p_drdy = 1'b0;
      tick();
      c_srdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         p_drdy = pat3[i];
         #1;
         check("t3_srdy", 64'(p_srdy), 64'(1'b1));
         check("t3_data", 64'(p_data), 64'(exp3[i]));
         check("t3_cdrdy", 64'(c_drdy), 64'(i == 9));
         tick();
      end
      check("t3_done_srdy", 64'(p_srdy), 64'(1'b0));

      // Reset in the middle of a word
      c_data = 64'hE004_E003_E002_E001; c_nbeats = 2'd3; c_srdy = 1'b1; p_drdy = 1'b1;
      tick();
      c_srdy = 1'b0;
      #1;
      check("t4_b0_data", 64'(p_data), 64'hE001);
      tick();
      check("t4_b1_data", 64'(p_data), 64'hE002);
      reset = 1'b1;
      #1;
      check("t4_reset_cdrdy", 64'(c_drdy), 64'(1'b0));
      tick();
      reset = 1'b0;
      #1;
      check("t4_after_reset_srdy", 64'(p_srdy), 64'(1'b0));
      check("t4_after_reset_cdrdy", 64'(c_drdy), 64'(1'b1));
      tick();
      check("t4_no_leftover_srdy", 64'(p_srdy), 64'(1'b0));
      c_data = 64'hF004_F003_F002_F001; c_nbeats = 2'd1; c_srdy = 1'b1;
      tick();
      c_srdy = 1'b0;
      #1;
      check("t4_next_b0", 64'(p_data), 64'hF001);
      tick();
      check("t4_next_b1", 64'(p_data), 64'hF002);
      check("t4_next_b1_cdrdy", 64'(c_drdy), 64'(1'b1));
      tick();
      check("t4_next_done", 64'(p_srdy), 64'(1'b0));

`ifdef SD_DNSIZE_LAST_EN
      // p_last on a 1-beat word followed by a 4-beat word
      c_data = 64'h0000_0000_0000_9001; c_nbeats = 2'd0; c_srdy = 1'b1; p_drdy = 1'b1;
      tick();
      c_data = 64'h8004_8003_8002_8001; c_nbeats = 2'd3;
      #1;
      check("t5_g0_data", 64'(p_data), 64'h9001);
      check("t5_g0_last", 64'(p_last), 64'(1'b1));
      tick();
      c_srdy = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("t5_h_data", 64'(p_data), 64'(16'h8001 + 16'(i)));
         check("t5_h_last", 64'(p_last), 64'(i == 3));
         tick();
      end
      check("t5_done_last", 64'(p_last), 64'(1'b0));
`endif

      // Random srdy/drdy stress against a beat scoreboard
      pushed = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      c_srdy = 1'b0;
      for (int cyc = 0; cyc < 60000 && (pushed < NW || exp_q.size() != 0); cyc++) begin
         if (!c_srdy && pushed < NW && $urandom_range(0, 3) != 0) begin
            c_data   = {$urandom, $urandom};
            c_nbeats = 2'($urandom_range(0, 3));
            c_srdy   = 1'b1;
         end
         p_drdy = ($urandom_range(0, 9) < 7);
         #1;
         if (prev_stall) begin
            check("stress_hold_srdy", 64'(p_srdy), 64'(1'b1));
            check("stress_hold_data", 64'(p_data), 64'(prev_data));
         end
         if (p_srdy && p_drdy) begin
            check("stress_beat_expected", 64'(exp_q.size() != 0), 64'(1'b1));
            if (exp_q.size() != 0) check("stress_data", 64'(p_data), 64'(exp_q.pop_front()));
         end
         took = c_srdy && c_drdy;
         if (took) begin
            word = c_data;
            for (int k = 0; k <= int'(c_nbeats); k++) exp_q.push_back(word[k*16 +: 16]);
            pushed++;
         end
         prev_stall = p_srdy && !p_drdy;
         prev_data  = p_data;
         tick();
         if (took) c_srdy = 1'b0;
      end
      check("stress_words_pushed", 64'(pushed), 64'(NW));
      check("stress_queue_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
